db9_joy_splitter: RTL

Scans one or more DB9 game controllers on a single shared DB9 port and returns one positive-logic joystick word per player.
- Drives the external splitter select lines so several physical pads can share the port.
- Runs a timed Mega Drive select-pin sequence for each pad, reading 3-button, 6-button and plain Atari-style pads.
- Sits between the top-level DB9 pins and the core's player input mapping, alongside the hps_io joystick words.

---
 rtl/db9_joy_splitter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/db9_joy_splitter.sv
// DB9 pad scanner: Mega Drive 3/6-button and Atari pads behind a splitter; DB9_JOY_DEBOUNCE_EN gates commits on two equal scans.
// Latency: SETTLE_CYC + 8*PHASE_CYC + 1 cycles per slot; no backpressure, joy_out holds between commits.
module db9_joy_splitter #(
  parameter int NUM_PLAYERS = 2,
  parameter int PHASE_CYC   = 64,
  parameter int SETTLE_CYC  = 32,
  localparam int PL_W       = (NUM_PLAYERS == 4) ? 2 : 1
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic [1:0]               mode,
  input  logic [5:0]               db9_in,
  output logic                     db9_select,
  output logic [PL_W-1:0]          splitter_sel,
  output logic [12*NUM_PLAYERS-1:0] joy_out,
  output logic [NUM_PLAYERS-1:0]   pad6,
  output logic                     frame_tick
);

  localparam int CNT_MAX = (PHASE_CYC > SETTLE_CYC) ? PHASE_CYC : SETTLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX);

  typedef enum logic [1:0] {S_OFF, S_SETTLE, S_PHASE, S_COMMIT} state_t;

  state_t            state_q, state_d;
  logic [2:0]        phase_q, phase_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PL_W-1:0]   slot_q, slot_d;
  logic [1:0]        mode_q;
  logic [11:0]       shadow_q;
  logic              md_q, six_q;

  logic              mode_chg, split_mode, phase_end, commit_wr, frame_d, md_now;
  logic [PL_W-1:0]   tgt;
  logic [5:0]        pr;

`ifdef DB9_JOY_DEBOUNCE_EN
  logic [12:0]       prev_q [NUM_PLAYERS];
`endif

  assign pr           = ~db9_in;
  assign md_now       = pr[1] & pr[0];
  assign splitter_sel = slot_q;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    slot_d     = slot_q;
    mode_chg   = (mode != mode_q);
    split_mode = (mode == 2'b10);
    phase_end  = (cnt_q == CNT_W'(PHASE_CYC - 1));
    tgt        = split_mode ? slot_q : PL_W'(mode[0]);
    commit_wr  = (state_q == S_COMMIT) && !mode_chg;
    frame_d    = commit_wr && (!split_mode || slot_q == PL_W'(NUM_PLAYERS - 1));

    case (state_q)
      S_OFF: begin
        if (mode != 2'b11) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
          slot_d  = '0;
        end
      end
      S_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          state_d = S_PHASE;
          phase_d = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PHASE: begin
        if (phase_end) begin
          cnt_d = '0;
          if (phase_q == 3'd7) state_d = S_COMMIT;
          else                 phase_d = phase_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_COMMIT: begin
        state_d = S_SETTLE;
        cnt_d   = '0;
        phase_d = '0;
        if (split_mode && slot_q != PL_W'(NUM_PLAYERS - 1)) slot_d = slot_q + PL_W'(1);
        else                                                slot_d = '0;
      end
      default: state_d = S_OFF;
    endcase

    // A mode change overrides whatever the scan was doing and restarts at slot 0.
    if (mode_chg) begin
      state_d = (mode == 2'b11) ? S_OFF : S_SETTLE;
      cnt_d   = '0;
      phase_d = '0;
      slot_d  = '0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= (mode == 2'b11) ? S_OFF : S_SETTLE;
      phase_q    <= '0;
      cnt_q      <= '0;
      slot_q     <= '0;
      mode_q     <= mode;
      db9_select <= 1'b1;
      joy_out    <= '0;
      pad6       <= '0;
      frame_tick <= 1'b0;
      shadow_q   <= '0;
      md_q       <= 1'b0;
      six_q      <= 1'b0;
`ifdef DB9_JOY_DEBOUNCE_EN
      for (int p = 0; p < NUM_PLAYERS; p++) prev_q[p] <= '0;
`endif
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      slot_q     <= slot_d;
      mode_q     <= mode;
      db9_select <= (state_d == S_PHASE) ? ~phase_d[0] : 1'b1;
      frame_tick <= frame_d;

      if (state_q != S_PHASE) begin
        shadow_q <= '0;
        md_q     <= 1'b0;
        six_q    <= 1'b0;
      end else if (phase_end) begin
        case (phase_q)
          3'd0: shadow_q[5:0] <= {pr[5], pr[4], pr[0], pr[1], pr[2], pr[3]};
          3'd1: begin
            md_q          <= md_now;
            shadow_q[7:6] <= md_now ? {pr[5], pr[4]} : 2'b00;
          end
          3'd5: six_q <= md_q & (&pr[3:0]);
          3'd6: shadow_q[11:8] <= six_q ? {pr[0], pr[1], pr[2], pr[3]} : 4'b0000;
          default: ;
        endcase
      end

      if (commit_wr) begin
`ifdef DB9_JOY_DEBOUNCE_EN
        prev_q[tgt] <= {six_q, shadow_q};
        if ({six_q, shadow_q} == prev_q[tgt]) begin
          joy_out[12*int'(tgt) +: 12] <= shadow_q;
          pad6[tgt]                   <= six_q;
        end
`else
        joy_out[12*int'(tgt) +: 12] <= shadow_q;
        pad6[tgt]                   <= six_q;
`endif
      end

      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (mode_chg && !((mode == 2'b10) || (mode == 2'b00 && p == 0) ||
                          (mode == 2'b01 && p == 1))) begin
          joy_out[12*p +: 12] <= '0;
          pad6[p]             <= 1'b0;
        end
      end
    end
  end

endmodule
